// File: rtl/pipe_stage_ctx.sv
// Pipeline-boundary register {valid, bundle} with stall, flush, bubble insertion
// and a small stack that saves and restores stage contents across nested interrupts.
module pipe_stage_ctx #(
   parameter int WIDTH = 143,
   parameter int CTX_DEPTH = 2,
   localparam int LW = $clog2(CTX_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             stall,
   input  logic             flush,
   input  logic             int_save,
   input  logic             int_restore,
   input  logic             clr_err,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic [LW-1:0]    ctx_level,
   output logic             ctx_overflow,
   output logic             ctx_underflow
);

   localparam int IW = (CTX_DEPTH > 1) ? $clog2(CTX_DEPTH) : 1;
   localparam logic [LW-1:0] FULL = LW'(CTX_DEPTH);

   logic             v;
   logic             v_nxt;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] d_nxt;
   logic [LW-1:0]    lvl;
   logic [LW-1:0]    lvl_nxt;
   logic             ovf;
   logic             ovf_nxt;
   logic             unf;
   logic             unf_nxt;
   logic             set_ovf;
   logic             set_unf;
   logic             push;
   logic [IW-1:0]    push_idx;
   logic [IW-1:0]    pop_idx;

   logic             stk_v [CTX_DEPTH];
   logic [WIDTH-1:0] stk_d [CTX_DEPTH];

   assign push_idx = IW'(lvl);
   assign pop_idx  = IW'(lvl - 1'b1);

   // Priority chain: save > restore > flush > stall > load.
   // Every path that clears v also clears d, so popped entries keep that invariant too.
   always_comb begin
      v_nxt   = v;
      d_nxt   = d;
      lvl_nxt = lvl;
      push    = 1'b0;
      set_ovf = 1'b0;
      set_unf = 1'b0;
      if (int_save) begin
         v_nxt = 1'b0;
         d_nxt = '0;
         if (lvl != FULL) begin
            push    = 1'b1;
            lvl_nxt = lvl + 1'b1;
         end else begin
            set_ovf = 1'b1;
         end
      end else if (int_restore) begin
         if (lvl != '0) begin
            v_nxt   = stk_v[pop_idx];
            d_nxt   = stk_d[pop_idx];
            lvl_nxt = lvl - 1'b1;
         end else begin
            v_nxt   = 1'b0;
            d_nxt   = '0;
            set_unf = 1'b1;
         end
      end else if (flush) begin
         v_nxt = 1'b0;
         d_nxt = '0;
      end else if (!stall) begin
         v_nxt = in_valid;
         d_nxt = in_valid ? in_data : '0;
      end
      ovf_nxt = set_ovf | (ovf & ~clr_err);
      unf_nxt = set_unf | (unf & ~clr_err);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v   <= 1'b0;
         d   <= '0;
         lvl <= '0;
         ovf <= 1'b0;
         unf <= 1'b0;
      end else begin
         v   <= v_nxt;
         d   <= d_nxt;
         lvl <= lvl_nxt;
         ovf <= ovf_nxt;
         unf <= unf_nxt;
      end
   end

   // Stack entries change only on a push; the live stage is captured before it is squashed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < CTX_DEPTH; i++) begin
            stk_v[i] <= 1'b0;
            stk_d[i] <= '0;
         end
      end else if (push) begin
         stk_v[push_idx] <= v;
         stk_d[push_idx] <= d;
      end
   end

   assign out_valid     = v & ~int_save;
   assign out_data      = int_save ? '0 : d;
   assign ctx_level     = lvl;
   assign ctx_overflow  = ovf;
   assign ctx_underflow = unf;

endmodule

// File: tb/tb_pipe_stage_ctx.sv
// Directed bench for pipe_stage_ctx (WIDTH=32, CTX_DEPTH=2): expected post-edge state is
// queued as each step is driven and popped for comparison once the edge has happened.
module tb_pipe_stage_ctx;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [31:0] in_data;
   logic        stall;
   logic        flush;
   logic        int_save;
   logic        int_restore;
   logic        clr_err;
   logic        out_valid;
   logic [31:0] out_data;
   logic [1:0]  ctx_level;
   logic        ctx_overflow;
   logic        ctx_underflow;

   typedef struct packed {
      logic        v;
      logic [31:0] d;
      logic [1:0]  lvl;
      logic        ovf;
      logic        unf;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;

   pipe_stage_ctx #(.WIDTH(32), .CTX_DEPTH(2)) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_data(in_data),
      .stall(stall),
      .flush(flush),
      .int_save(int_save),
      .int_restore(int_restore),
      .clr_err(clr_err),
      .out_valid(out_valid),
      .out_data(out_data),
      .ctx_level(ctx_level),
      .ctx_overflow(ctx_overflow),
      .ctx_underflow(ctx_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input exp_t e);
      check_output({tag, "_valid"}, 64'(out_valid), 64'(e.v));
      check_output({tag, "_data"}, 64'(out_data), 64'(e.d));
      check_output({tag, "_level"}, 64'(ctx_level), 64'(e.lvl));
      check_output({tag, "_ovf"}, 64'(ctx_overflow), 64'(e.ovf));
      check_output({tag, "_unf"}, 64'(ctx_underflow), 64'(e.unf));
   endtask

   // Drives one cycle of controls, checks the same-cycle squash while int_save is high,
   // then returns the inputs to idle after the edge and compares against the queued result.
   task automatic apply_stimulus(input string tag, input logic iv, input logic [31:0] id,
                                 input logic st, input logic fl, input logic sv,
                                 input logic rs, input logic ce, input exp_t e);
      exp_t  got;
      string t;
      in_valid    = iv;
      in_data     = id;
      stall       = st;
      flush       = fl;
      int_save    = sv;
      int_restore = rs;
      clr_err     = ce;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      #1;
      if (sv) begin
         check_output({tag, "_sq_valid"}, 64'(out_valid), 64'd0);
         check_output({tag, "_sq_data"}, 64'(out_data), 64'd0);
      end
      @(posedge clk);
      #1;
      in_valid    = 1'b0;
      in_data     = '0;
      stall       = 1'b0;
      flush       = 1'b0;
      int_save    = 1'b0;
      int_restore = 1'b0;
      clr_err     = 1'b0;
      #1;
      if (exp_q.size() == 0) begin
         check_output({tag, "_queue"}, 64'd0, 64'd1);
      end else begin
         got = exp_q.pop_front();
         t   = tag_q.pop_front();
         check_all(t, got);
      end
   endtask

   function automatic exp_t mk(input logic v, input logic [31:0] d, input logic [1:0] l,
                               input logic o, input logic u);
      mk = '{v: v, d: d, lvl: l, ovf: o, unf: u};
   endfunction

   initial begin
      reset       = 1'b0;
      in_valid    = 1'b1;
      in_data     = 32'hA5A5_0001;
      stall       = 1'b0;
      flush       = 1'b0;
      int_save    = 1'b0;
      int_restore = 1'b0;
      clr_err     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all("rst", mk(1'b0, 32'h0, 2'd0, 1'b0, 1'b0));
      reset = 1'b1;

      apply_stimulus("load_a5", 1, 32'hA5A5_0001, 0, 0, 0, 0, 0, mk(1, 32'hA5A5_0001, 0, 0, 0));
      apply_stimulus("load_inv", 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, mk(0, 32'h0, 0, 0, 0));

      apply_stimulus("load_11", 1, 32'h11, 0, 0, 0, 0, 0, mk(1, 32'h11, 0, 0, 0));
      for (int i = 0; i < 3; i++)
         apply_stimulus("stall", 1, 32'h22, 1, 0, 0, 0, 0, mk(1, 32'h11, 0, 0, 0));
      apply_stimulus("stall_flush", 1, 32'h22, 1, 1, 0, 0, 0, mk(0, 32'h0, 0, 0, 0));

      apply_stimulus("load_aa", 1, 32'hAA, 0, 0, 0, 0, 0, mk(1, 32'hAA, 0, 0, 0));
      apply_stimulus("save1", 0, 32'h0, 0, 0, 1, 0, 0, mk(0, 32'h0, 1, 0, 0));
      apply_stimulus("load_bb", 1, 32'hBB, 0, 0, 0, 0, 0, mk(1, 32'hBB, 1, 0, 0));
      apply_stimulus("save2", 0, 32'h0, 0, 0, 1, 0, 0, mk(0, 32'h0, 2, 0, 0));
      apply_stimulus("rest_bb", 1, 32'h99, 1, 1, 0, 1, 0, mk(1, 32'hBB, 1, 0, 0));
      apply_stimulus("rest_aa", 0, 32'h0, 0, 0, 0, 1, 0, mk(1, 32'hAA, 0, 0, 0));

      // Second push captures the bubble left by the first, so the first pop returns a bubble.
      apply_stimulus("ovf_s1", 0, 32'h0, 0, 0, 1, 0, 0, mk(0, 32'h0, 1, 0, 0));
      apply_stimulus("ovf_s2", 0, 32'h0, 0, 0, 1, 0, 0, mk(0, 32'h0, 2, 0, 0));
      apply_stimulus("ovf_s3", 0, 32'h0, 0, 0, 1, 0, 0, mk(0, 32'h0, 2, 1, 0));
      apply_stimulus("unf_r1", 0, 32'h0, 0, 0, 0, 1, 0, mk(0, 32'h0, 1, 1, 0));
      apply_stimulus("unf_r2", 0, 32'h0, 0, 0, 0, 1, 0, mk(1, 32'hAA, 0, 1, 0));
      apply_stimulus("unf_r3", 0, 32'h0, 0, 0, 0, 1, 0, mk(0, 32'h0, 0, 1, 1));
      apply_stimulus("clr", 0, 32'h0, 0, 0, 0, 0, 1, mk(0, 32'h0, 0, 0, 0));
      apply_stimulus("set_wins", 0, 32'h0, 0, 0, 0, 1, 1, mk(0, 32'h0, 0, 0, 1));
      apply_stimulus("clr2", 0, 32'h0, 0, 0, 0, 0, 1, mk(0, 32'h0, 0, 0, 0));

      apply_stimulus("load_33", 1, 32'h33, 0, 0, 0, 0, 0, mk(1, 32'h33, 0, 0, 0));
      apply_stimulus("sv_33", 0, 32'h0, 0, 0, 1, 0, 0, mk(0, 32'h0, 1, 0, 0));
      apply_stimulus("load_44", 1, 32'h44, 0, 0, 0, 0, 0, mk(1, 32'h44, 1, 0, 0));
      apply_stimulus("sv_rs", 0, 32'h0, 0, 0, 1, 1, 0, mk(0, 32'h0, 2, 0, 0));
      apply_stimulus("rest_44", 0, 32'h0, 0, 0, 0, 1, 0, mk(1, 32'h44, 1, 0, 0));
      apply_stimulus("load_55", 1, 32'h55, 0, 0, 0, 0, 0, mk(1, 32'h55, 1, 0, 0));
      apply_stimulus("sv_55", 0, 32'h0, 0, 0, 1, 0, 0, mk(0, 32'h0, 2, 0, 0));
      apply_stimulus("ovf_again", 0, 32'h0, 0, 0, 1, 0, 0, mk(0, 32'h0, 2, 1, 0));
      apply_stimulus("load_66", 1, 32'h66, 0, 0, 0, 0, 0, mk(1, 32'h66, 2, 1, 0));

      #2;
      reset = 1'b0;
      #1;
      check_all("async_rst", mk(0, 32'h0, 0, 0, 0));
      @(posedge clk);
      #1;
      reset = 1'b1;
      apply_stimulus("post_rst_pop", 0, 32'h0, 0, 0, 0, 1, 0, mk(0, 32'h0, 0, 0, 1));

      check_output("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_stage_ctx.md
# pipe_stage_ctx

Parametrised pipeline-boundary register with bubble insertion, stall, flush and an interrupt context stack. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and carries a packed bundle of stage signals plus a valid bit. Nested interrupts are supported: each interrupt entry pushes the live stage contents onto a `CTX_DEPTH`-deep stack, and each return pops them back, with overflow and underflow reported.

## Interface
- `WIDTH`, 143, width of the packed stage bundle in bits (≥1).
- `CTX_DEPTH`, 2, number of nested interrupt contexts held (≥1).
- `LW`, `$clog2(CTX_DEPTH+1)`, local width of the level counter; not overridable.
- `clk`  input  1  rising-edge clock, the only clock.
- `reset`  input  1  asynchronous, active-low reset; 0 resets, 1 runs.
- `in_valid`  input  1  upstream bundle is a real instruction.
- `in_data`  input  WIDTH  upstream packed bundle.
- `stall`  input  1  hold the current contents.
- `flush`  input  1  load a bubble.
- `int_save`  input  1  interrupt entry: push the context, squash the output.
- `int_restore`  input  1  interrupt return: pop the context.
- `clr_err`  input  1  clear the sticky error flags.
- `out_valid`  output  1  downstream valid.
- `out_data`  output  WIDTH  downstream bundle.
- `ctx_level`  output  LW  number of contexts currently stacked.
- `ctx_overflow`  output  1  sticky flag: a push was attempted with the stack full.
- `ctx_underflow`  output  1  sticky flag: a pop was attempted with the stack empty.

## Operation
- State held by the block:
  - stage register {v, d};
  - stack of `CTX_DEPTH` entries, each {v, d};
  - level counter `lvl`;
  - two sticky flags.
- A bubble is {v=0, d=0}. The stage register always holds `d=0` whenever `v=0`.
- Priority per cycle, highest first: `int_save` > `int_restore` > `flush` > `stall` > load.
- `int_save`:
  - If `lvl<CTX_DEPTH`: push {v, d} to entry[lvl], `lvl`+=1, stage register becomes a bubble.
  - Else: no push, stage register becomes a bubble, `ctx_overflow`←1, `lvl` unchanged.
  - If `int_restore` is asserted in the same cycle, it is ignored.
- `int_restore` (with `int_save`=0):
  - If `lvl>0`: stage register ← entry[lvl-1], `lvl`-=1.
  - Else: stage register becomes a bubble, `ctx_underflow`←1.
  - `flush` and `stall` are ignored in this cycle.
- `flush`: stage register becomes a bubble. `flush` wins over `stall`.
- `stall`: stage register unchanged. `in_*` is ignored.
- Load: `v`←`in_valid`, `d`←(`in_valid` ? `in_data` : 0).
- Error flags:
  - Set by the events above; hold until `clr_err`=1 or reset.
  - If a set event and `clr_err` occur in the same cycle, set wins.
- Stack entries are written only by a push and are never cleared except by reset.
- Output squash (combinational): while `int_save`=1, `out_valid`=0 and `out_data`=0 in that same cycle, independent of register contents.
- Otherwise, `out_valid`=`v` and `out_data`=`d`.

## Timing
- Latency: one cycle from `in_*` to `out_*` on a load.
- Push and pop take effect at the clock edge. `ctx_level` updates at the same edge.
- Flags are asserted the cycle after the offending edge's sample.
- Reset (`reset`=0, asynchronous, takes effect immediately, including mid-operation):
  - `out_valid`=0, `out_data`=0, `ctx_level`=0, `ctx_overflow`=0, `ctx_underflow`=0;
  - all stack entries cleared to 0.
- Release of reset is synchronous to the next rising edge. The first edge with `reset`=1 performs a normal priority evaluation.
- `int_save` held for N consecutive cycles performs N pushes. The controller pulses it for one cycle per interrupt entry.
- `ctx_level` saturates at `CTX_DEPTH` and at 0; it never wraps.

## Test plan
- **Reset then stream:** hold `reset`=0 for 2 cycles, then load `in_data`=32'hA5A5_0001 (`WIDTH`=32, `in_valid`=1).
  - During reset: all outputs are 0.
  - One cycle after the load edge: `out_valid`=1, `out_data`=A5A5_0001.
- **Stall/flush:** register holds 0x11, `in_data`=0x22.
  - `stall`=1 for 3 cycles → `out_data` stays 0x11.
  - `stall`=1 and `flush`=1 together → `out_valid`=0, `out_data`=0.
- **Nested interrupts (`CTX_DEPTH`=2):**
  - Register holds 0xAA; pulse `int_save` → `out_*`=0 during the pulse cycle, `ctx_level`=1.
  - Load 0xBB; pulse `int_save` → `ctx_level`=2.
  - Pulse `int_restore` → `out_data`=0xBB, `ctx_level`=1.
  - Pulse `int_restore` → `out_data`=0xAA, `ctx_level`=0.
- **Overflow/underflow:**
  - Three `int_save` pulses with `CTX_DEPTH`=2 → `ctx_level`=2, `ctx_overflow`=1.
  - Three `int_restore` pulses → third gives a bubble and `ctx_underflow`=1.
  - `clr_err` pulse → both flags return to 0.
- **Simultaneous save+restore:** at `lvl`=1, assert both → push occurs, `ctx_level`=2, no pop.
- **Async reset mid-operation:** drive `reset`=0 between edges with `lvl`=2 and `ctx_overflow`=1 → outputs, `ctx_level` and flags go to 0 immediately, before the next edge.
